// File: rtl/aib_mac_link_seq_if.sv
// Signal bundle between the MAC-side link sequencer and the logic that drives it.
// The slave modport is the sequencer's view; the master modport is the MAC/adapter side.
interface aib_mac_link_seq_if #(
    parameter int MAX_RETRY = 3
) ();
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic          i_link_en;
    logic          i_conf_done;
    logic          i_fs_mac_rdy;
    logic          i_tx_transfer_en;
    logic          i_rx_transfer_en;
    logic          i_rx_align_done;
    logic          o_ns_adapter_rstn;
    logic          o_ns_mac_rdy;
    logic          o_tx_lock_req;
    logic          o_rx_lock_req;
    logic          o_data_en;
    logic          o_link_up;
    logic          o_timeout_err;
    logic [RW-1:0] o_retry_cnt;
    logic [2:0]    o_state;

    modport master (
        output i_link_en, i_conf_done, i_fs_mac_rdy, i_tx_transfer_en,
               i_rx_transfer_en, i_rx_align_done,
        input  o_ns_adapter_rstn, o_ns_mac_rdy, o_tx_lock_req, o_rx_lock_req,
               o_data_en, o_link_up, o_timeout_err, o_retry_cnt, o_state
    );

    modport slave (
        input  i_link_en, i_conf_done, i_fs_mac_rdy, i_tx_transfer_en,
               i_rx_transfer_en, i_rx_align_done,
        output o_ns_adapter_rstn, o_ns_mac_rdy, o_tx_lock_req, o_rx_lock_req,
               o_data_en, o_link_up, o_timeout_err, o_retry_cnt, o_state
    );
endinterface

// File: rtl/aib_mac_link_seq.sv
// MAC-side AIB link bring-up sequencer: adapter reset, mac_rdy, lock requests, then
// datapath enable once far side, transfer_en handshake and RX alignment are all seen.
module aib_mac_link_seq #(
    parameter int SYNC_STAGES  = 2,
    parameter int RST_HOLD_CYC = 16,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic              i_osc_clk,
    input  logic              i_rstn,
    aib_mac_link_seq_if.slave bus
);
    localparam int RW      = $clog2(MAX_RETRY + 1);
    localparam int CNT_MAX = (RST_HOLD_CYC > TIMEOUT_CYC) ? RST_HOLD_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int NIN     = 6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_MAC_RDY  = 3'd2,
        S_LOCK_REQ = 3'd3,
        S_ALIGN    = 3'd4,
        S_LINK_UP  = 3'd5,
        S_TEARDOWN = 3'd6,
        S_FAIL     = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0]                  raw_in;
    logic link_en_s, conf_done_s, fs_mac_rdy_s, tx_xfer_s, rx_xfer_s, align_done_s;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_cnt;
    logic          timeout_hit;
    logic          hold_done;
    logic          wait_expired;
    logic          ns_adapter_rstn;
    logic          ns_mac_rdy;
    logic          lock_req;
    logic          data_en;
    logic          link_up;
    logic          timeout_err;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CW'(CNT_MAX)) ? v : v + 1'b1;
    endfunction

    assign raw_in = {bus.i_link_en, bus.i_conf_done, bus.i_fs_mac_rdy,
                     bus.i_tx_transfer_en, bus.i_rx_transfer_en, bus.i_rx_align_done};

    always_ff @(posedge i_osc_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign {link_en_s, conf_done_s, fs_mac_rdy_s, tx_xfer_s, rx_xfer_s, align_done_s} =
        sync_q[SYNC_STAGES-1];

    assign hold_done    = (cnt == CW'(RST_HOLD_CYC - 1));
    assign wait_expired = (cnt == CW'(TIMEOUT_CYC - 1));

    // Exit condition beats timeout; loss of link_en beats both.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:     if (link_en_s && conf_done_s) next_state = S_RST_HOLD;
            S_RST_HOLD: if (hold_done) next_state = S_MAC_RDY;
            S_MAC_RDY: begin
                if (fs_mac_rdy_s)      next_state  = S_LOCK_REQ;
                else if (wait_expired) timeout_hit = 1'b1;
            end
            S_LOCK_REQ: begin
                if (tx_xfer_s && rx_xfer_s) next_state  = S_ALIGN;
                else if (wait_expired)      timeout_hit = 1'b1;
            end
            S_ALIGN: begin
                if (align_done_s)      next_state  = S_LINK_UP;
                else if (wait_expired) timeout_hit = 1'b1;
            end
            S_LINK_UP: begin
                if (!(fs_mac_rdy_s && tx_xfer_s && rx_xfer_s)) next_state = S_TEARDOWN;
            end
            S_TEARDOWN: next_state = S_RST_HOLD;
            S_FAIL:     next_state = S_FAIL;
            default:    next_state = S_IDLE;
        endcase
        if (timeout_hit) begin
            next_state = (retry_cnt < RW'(MAX_RETRY)) ? S_RST_HOLD : S_FAIL;
        end
        if (!link_en_s && state != S_IDLE) begin
            next_state  = S_IDLE;
            timeout_hit = 1'b0;
        end
    end

    // Outputs are decoded from next_state so they move together with the state register.
    always_ff @(posedge i_osc_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state           <= S_IDLE;
            cnt             <= '0;
            retry_cnt       <= '0;
            ns_adapter_rstn <= 1'b0;
            ns_mac_rdy      <= 1'b0;
            lock_req        <= 1'b0;
            data_en         <= 1'b0;
            link_up         <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : sat_inc(cnt);
            if (next_state == S_IDLE || next_state == S_LINK_UP) begin
                retry_cnt <= '0;
            end else if (timeout_hit && next_state == S_RST_HOLD) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            ns_adapter_rstn <= next_state inside {S_MAC_RDY, S_LOCK_REQ, S_ALIGN,
                                                  S_LINK_UP, S_TEARDOWN};
            ns_mac_rdy      <= next_state inside {S_MAC_RDY, S_LOCK_REQ, S_ALIGN, S_LINK_UP};
            lock_req        <= next_state inside {S_LOCK_REQ, S_ALIGN, S_LINK_UP};
            data_en         <= (next_state == S_LINK_UP);
            link_up         <= (next_state == S_LINK_UP);
            timeout_err     <= (next_state == S_FAIL);
        end
    end

    assign bus.o_ns_adapter_rstn = ns_adapter_rstn;
    assign bus.o_ns_mac_rdy      = ns_mac_rdy;
    assign bus.o_tx_lock_req     = lock_req;
    assign bus.o_rx_lock_req     = lock_req;
    assign bus.o_data_en         = data_en;
    assign bus.o_link_up         = link_up;
    assign bus.o_timeout_err     = timeout_err;
    assign bus.o_retry_cnt       = retry_cnt;
    assign bus.o_state           = state;
endmodule

// File: tb/tb_aib_mac_link_seq.sv
// Bench for aib_mac_link_seq: cycle-level reference model compared every cycle,
// plus directed bring-up, timeout, teardown, boundary and reset scenarios.
module tb_aib_mac_link_seq;
    localparam int S  = 2;
    localparam int RH = 16;
    localparam int TO = 1024;
    localparam int MR = 3;

    // Per-state output maps, bit index = state number.
    localparam bit [7:0] RSTN_MAP = 8'b0111_1100;
    localparam bit [7:0] MAC_MAP  = 8'b0011_1100;
    localparam bit [7:0] LOCK_MAP = 8'b0011_1000;
    localparam bit [7:0] UP_MAP   = 8'b0010_0000;
    localparam bit [7:0] ERR_MAP  = 8'b1000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    aib_mac_link_seq_if #(.MAX_RETRY(MR)) bus ();

    aib_mac_link_seq #(
        .SYNC_STAGES (S),
        .RST_HOLD_CYC(RH),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .i_osc_clk(clk),
        .i_rstn   (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: inputs delayed S cycles through a queue, dwell = cycles spent in state.
    logic [5:0] dq[$];
    logic [5:0] md;
    int m_state = 0;
    int m_dwell = 0;
    int m_retry = 0;
    int mnxt;
    bit mto;

    function automatic logic [5:0] cur_in();
        return {bus.i_link_en, bus.i_conf_done, bus.i_fs_mac_rdy,
                bus.i_tx_transfer_en, bus.i_rx_transfer_en, bus.i_rx_align_done};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq.delete();
            for (int i = 0; i < S; i++) dq.push_back(6'b0);
            m_state = 0;
            m_dwell = 0;
            m_retry = 0;
        end else begin
            md = dq.pop_front();
            dq.push_back(cur_in());
            mnxt = m_state;
            mto  = 1'b0;
            if (m_state != 0 && !md[5]) begin
                mnxt = 0;
            end else begin
                case (m_state)
                    0: if (md[5] && md[4]) mnxt = 1;
                    1: if (m_dwell == RH - 1) mnxt = 2;
                    2: if (md[3]) mnxt = 3; else mto = (m_dwell == TO - 1);
                    3: if (md[2] && md[1]) mnxt = 4; else mto = (m_dwell == TO - 1);
                    4: if (md[0]) mnxt = 5; else mto = (m_dwell == TO - 1);
                    5: if (!(md[3] && md[2] && md[1])) mnxt = 6;
                    6: mnxt = 1;
                    default: mnxt = m_state;
                endcase
            end
            if (mto) begin
                if (m_retry < MR) begin
                    m_retry++;
                    mnxt = 1;
                end else begin
                    mnxt = 7;
                end
            end
            if (mnxt == 0 || mnxt == 5) m_retry = 0;
            m_dwell = (mnxt == m_state) ? m_dwell + 1 : 0;
            m_state = mnxt;
        end
    end

    function automatic logic [11:0] exp_vec(input int st, input int rt);
        logic [2:0] s3;
        logic [1:0] r2;
        s3 = 3'(st);
        r2 = 2'(rt);
        return {RSTN_MAP[s3], MAC_MAP[s3], LOCK_MAP[s3], LOCK_MAP[s3],
                UP_MAP[s3], UP_MAP[s3], ERR_MAP[s3], r2, s3};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.o_ns_adapter_rstn, bus.o_ns_mac_rdy, bus.o_tx_lock_req, bus.o_rx_lock_req,
                bus.o_data_en, bus.o_link_up, bus.o_timeout_err, bus.o_retry_cnt, bus.o_state};
    endfunction

    always @(negedge clk) begin
        checks++;
        if (dut_vec() !== exp_vec(m_state, m_retry)) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_vec(),
                     exp_vec(m_state, m_retry));
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_in(input bit le, input bit cd, input bit fs,
                          input bit tx, input bit rx, input bit al);
        bus.i_link_en        = le;
        bus.i_conf_done      = cd;
        bus.i_fs_mac_rdy     = fs;
        bus.i_tx_transfer_en = tx;
        bus.i_rx_transfer_en = rx;
        bus.i_rx_align_done  = al;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input string name, input int target, input int bound);
        int n;
        n = 0;
        while (int'(bus.o_state) != target && n < bound) begin
            cyc();
            n++;
        end
        chk(name, int'(bus.o_state), target);
    endtask

    task automatic go_idle(input string name);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk(name, int'(bus.o_state), 0);
    endtask

    int first[8];
    int n_hold;
    int st;
    int first7;

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", int'(dut_vec()), 0);
        rst_n = 1'b1;

        // 1: normal bring-up with staggered far-side events
        for (int k = 0; k < 8; k++) first[k] = -1;
        n_hold = 0;
        for (int c = 0; c < 60; c++) begin
            set_in(1, 1, c >= 10, c >= 30, c >= 30, c >= 40);
            cyc();
            st = int'(bus.o_state);
            if (first[st] < 0) first[st] = c;
            if (st == 1) n_hold++;
        end
        chk("t1_enter_rst_hold", first[1], 2);
        chk("t1_enter_mac_rdy", first[2], 18);
        chk("t1_enter_lock_req", first[3], 19);
        chk("t1_enter_align", first[4], 32);
        chk("t1_enter_link_up", first[5], 42);
        chk("t1_rst_hold_len", n_hold, RH);
        chk("t1_link_up", int'(bus.o_link_up), 1);
        chk("t1_data_en", int'(bus.o_data_en), 1);
        chk("t1_retry", int'(bus.o_retry_cnt), 0);
        go_idle("t1_idle");

        // 2: far side never ready -> three retries then FAIL
        first7 = -1;
        for (int c = 0; c < 4170; c++) begin
            set_in(1, 1, 0, 1, 1, 1);
            cyc();
            if (c == 1041) chk("t2_last_wait_cycle", int'(bus.o_state), 2);
            if (c == 1042) begin
                chk("t2_retry_state", int'(bus.o_state), 1);
                chk("t2_retry_one", int'(bus.o_retry_cnt), 1);
            end
            if (first7 < 0 && bus.o_state == 3'd7) first7 = c;
        end
        chk("t2_fail_entry", first7, 4162);
        chk("t2_fail_retry", int'(bus.o_retry_cnt), 3);
        chk("t2_fail_err", int'(bus.o_timeout_err), 1);
        set_in(0, 1, 0, 1, 1, 1);
        cyc();
        cyc();
        chk("t2_fail_hold", int'(bus.o_state), 7);
        cyc();
        chk("t2_idle_state", int'(bus.o_state), 0);
        chk("t2_idle_err", int'(bus.o_timeout_err), 0);
        chk("t2_idle_retry", int'(bus.o_retry_cnt), 0);

        // 3: link loss in LINK_UP; conditions already true -> one state per cycle
        for (int k = 0; k < 8; k++) first[k] = -1;
        for (int c = 0; c < 30; c++) begin
            set_in(1, 1, 1, 1, 1, 1);
            cyc();
            st = int'(bus.o_state);
            if (first[st] < 0) first[st] = c;
        end
        chk("t3_no_skip_align", first[4], 20);
        chk("t3_no_skip_link_up", first[5], 21);
        set_in(1, 1, 1, 1, 0, 1);
        cyc();
        cyc();
        chk("t3_data_en_still", int'(bus.o_data_en), 1);
        cyc();
        chk("t3_data_en_fall", int'(bus.o_data_en), 0);
        chk("t3_teardown", int'(bus.o_state), 6);
        cyc();
        chk("t3_rst_hold", int'(bus.o_state), 1);
        chk("t3_retry", int'(bus.o_retry_cnt), 0);
        go_idle("t3_idle");

        // 4: alignment arrives in the last allowed ALIGN cycle
        set_in(1, 1, 1, 1, 1, 0);
        wait_state("t4_reach_align", 4, 100);
        for (int j = 1; j <= 1024; j++) begin
            set_in(1, 1, 1, 1, 1, j >= 1022);
            cyc();
            if (j == 1023) chk("t4_still_align", int'(bus.o_state), 4);
        end
        chk("t4_link_up", int'(bus.o_state), 5);
        chk("t4_retry", int'(bus.o_retry_cnt), 0);
        go_idle("t4_idle");

        // 5: async reset in ALIGN, then restart gated by conf_done
        set_in(1, 1, 1, 1, 1, 0);
        wait_state("t5_reach_align", 4, 100);
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", int'(dut_vec()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0, 1, 1, 1, 1);
        repeat (6) cyc();
        chk("t5_wait_conf", int'(bus.o_state), 0);
        set_in(1, 1, 1, 1, 1, 1);
        repeat (3) cyc();
        chk("t5_restart", int'(bus.o_state), 1);
        set_in(1, 0, 1, 1, 1, 1);
        repeat (20) cyc();
        chk("t5_conf_drop_ignored", int'(bus.o_state), 5);
        go_idle("t5_idle");

        // 6: software disable during LOCK_REQ
        set_in(1, 1, 1, 0, 0, 0);
        wait_state("t6_reach_lock", 3, 100);
        repeat (5) cyc();
        set_in(0, 1, 1, 0, 0, 0);
        cyc();
        cyc();
        chk("t6_still_lock", int'(bus.o_state), 3);
        cyc();
        chk("t6_idle", int'(bus.o_state), 0);
        chk("t6_rstn_low", int'(bus.o_ns_adapter_rstn), 0);
        chk("t6_tx_lock_off", int'(bus.o_tx_lock_req), 0);
        chk("t6_rx_lock_off", int'(bus.o_rx_lock_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
